// File: rtl/sync_stream_fifo.sv
// Single-clock valid/ready FIFO over distributed RAM with arbitrary depth,
// programmable almost-full/almost-empty thresholds, synchronous flush and fill count.
module sync_stream_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 24,
    parameter int ALMOST_FULL  = 20,
    parameter int ALMOST_EMPTY = 4,
    localparam int PtrW = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int CntW = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic [CntW-1:0]       o_fill_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_stream_fifo: DEPTH must be >= 2");
    end
    if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_af
        $error("sync_stream_fifo: ALMOST_FULL must be in 1..DEPTH");
    end
    if (ALMOST_EMPTY < 0 || ALMOST_EMPTY >= DEPTH) begin : g_bad_ae
        $error("sync_stream_fifo: ALMOST_EMPTY must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       fill_q, fill_d;
    logic                  push, pop;

    // Ready is decoded from registered fill only, so a pop at full never frees a slot
    // in the same cycle.
    assign o_full         = (fill_q == CntW'(DEPTH));
    assign o_empty        = (fill_q == '0);
    assign o_s_ready      = ~o_full;
    assign o_m_valid      = ~o_empty;
    assign o_almost_full  = (fill_q >= CntW'(ALMOST_FULL));
    assign o_almost_empty = (fill_q <= CntW'(ALMOST_EMPTY));
    assign o_fill_count   = fill_q;
    assign o_m_data       = mem_q[rd_ptr_q];

    assign push = i_s_valid & o_s_ready;
    assign pop  = o_m_valid & i_m_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (i_rst || i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                fill_d = fill_q + 1'b1;
            end else if (pop && !push) begin
                fill_d = fill_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        fill_q   <= fill_d;
    end

    // Storage is deliberately left out of reset so it maps onto distributed RAM.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst && !i_flush) begin
            mem_q[wr_ptr_q] <= i_s_data;
        end
    end

endmodule
